freecell_move_sequencer: RTL

//  Sits between player input and the FreeCell board datapath. Buffers player

---
 rtl/freecell_pkg.sv | 33 +++
 rtl/freecell_cmd_fifo.sv | 49 ++++
 rtl/freecell_move_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/freecell_pkg.sv
// Shared slot-code constants, sequencer state encoding and the move command
// payload for the FreeCell move sequencer.
package freecell_pkg;

  localparam int unsigned SLOT_W = 4;

  // Slot-code classes taken from the top bits of a 4-bit slot code.
  localparam logic             SLOT_TAB      = 1'b0;     // 0ccc
  localparam logic [1:0]       SLOT_FREE     = 2'b10;    // 10ff
  localparam logic [1:0]       SLOT_HOME     = 2'b11;    // 11xx
  localparam logic [SLOT_W-1:0] HOME_DST     = 4'b1100;
  localparam logic [SLOT_W-1:0] LAST_SCAN_SRC = 4'd11;   // last free cell

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SCAN  = 3'd4,
    S_HALT  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [SLOT_W-1:0] src;
    logic [SLOT_W-1:0] dst;
  } cmd_t;

  // A move may never take a card back out of a home pile.
  function automatic logic is_home(input logic [SLOT_W-1:0] slot);
    return slot[SLOT_W-1:SLOT_W-2] == SLOT_HOME;
  endfunction

endpackage

// File: rtl/freecell_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and a synchronous flush.
// Pointers carry one extra wrap bit to tell full from empty.
module freecell_cmd_fifo
  import freecell_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  cmd_t          mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/freecell_move_sequencer.sv
// FreeCell move sequencer: queues player moves, issues them to the board over
// a req/ack handshake with timeout, counts applied moves and freezes on win.
// Optional home sweep after each good move: define FREECELL_AUTO_HOME_EN.
module freecell_move_sequencer
  import freecell_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_src,
  input  logic [3:0]       cmd_dst,
  output logic             mv_req,
  output logic [3:0]       mv_src,
  output logic [3:0]       mv_dst,
  input  logic             mv_ack,
  input  logic             mv_ok,
  input  logic             win,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] move_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t        state, state_d;
  cmd_t              hold, hold_d, fifo_dout, fifo_din;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              req_d, ill_d, to_d, halt_d;
  logic [3:0]        src_d, dst_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              fifo_full, fifo_empty, push_c, pop_c, flush_c, move_ok_c;
`ifdef FREECELL_AUTO_HOME_EN
  logic [3:0]        scan_idx, scan_idx_d;
  logic              any_ok, any_ok_d, auto_mv, auto_mv_d;
`endif

  // Handshake-facing flags decoded from registered state.
  assign cmd_ready   = !fifo_full && !halted;
  assign busy        = (state != S_IDLE) || !fifo_empty;
  assign push_c      = cmd_valid && cmd_ready;
  assign flush_c     = win || (state == S_HALT);
  assign move_ok_c   = mv_ack && mv_ok;
  assign fifo_din.src = cmd_src;
  assign fifo_din.dst = cmd_dst;

  freecell_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .clear (flush_c),
    .push  (push_c),
    .din   (fifo_din),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and next-output logic; win overrides every state.
  always_comb begin
    state_d    = state;
    hold_d     = hold;
    wait_cnt_d = wait_cnt;
    req_d      = mv_req;
    src_d      = mv_src;
    dst_d      = mv_dst;
    ill_d      = 1'b0;
    to_d       = 1'b0;
    halt_d     = halted;
    cnt_d      = move_count;
    pop_c      = 1'b0;
`ifdef FREECELL_AUTO_HOME_EN
    scan_idx_d = scan_idx;
    any_ok_d   = any_ok;
    auto_mv_d  = auto_mv;
`endif
    if (win || state == S_HALT) begin
      state_d = S_HALT;
      req_d   = 1'b0;
      halt_d  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            hold_d  = fifo_dout;
            state_d = S_CHECK;
`ifdef FREECELL_AUTO_HOME_EN
            auto_mv_d = 1'b0;
`endif
          end
        end
        S_CHECK: begin
          if (is_home(hold.src) || hold.src == hold.dst) begin
            ill_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_d      = 1'b1;
          src_d      = hold.src;
          dst_d      = hold.dst;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (mv_ack || wait_cnt == WAIT_LAST) begin
            req_d = 1'b0;
            if (move_ok_c && !(&move_count)) cnt_d = move_count + CNT_W'(1);
`ifdef FREECELL_AUTO_HOME_EN
            if (!mv_ack) to_d = 1'b1;
            else if (!mv_ok && !auto_mv) ill_d = 1'b1;
            if (auto_mv) begin
              if (scan_idx == LAST_SCAN_SRC) begin
                if (any_ok || move_ok_c) begin
                  scan_idx_d = '0;
                  any_ok_d   = 1'b0;
                  state_d    = S_SCAN;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                scan_idx_d = scan_idx + 4'd1;
                any_ok_d   = any_ok || move_ok_c;
                state_d    = S_SCAN;
              end
            end else if (move_ok_c) begin
              scan_idx_d = '0;
              any_ok_d   = 1'b0;
              state_d    = S_SCAN;
            end else begin
              state_d = S_IDLE;
            end
`else
            if (!mv_ack) to_d = 1'b1;
            else if (!mv_ok) ill_d = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            wait_cnt_d = wait_cnt + WAIT_W'(1);
          end
        end
`ifdef FREECELL_AUTO_HOME_EN
        S_SCAN: begin
          hold_d.src = scan_idx;
          hold_d.dst = HOME_DST;
          auto_mv_d  = 1'b1;
          state_d    = S_ISSUE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, holding register and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hold        <= '0;
      wait_cnt    <= '0;
      mv_req      <= 1'b0;
      mv_src      <= '0;
      mv_dst      <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      halted      <= 1'b0;
      move_count  <= '0;
    end else begin
      state       <= state_d;
      hold        <= hold_d;
      wait_cnt    <= wait_cnt_d;
      mv_req      <= req_d;
      mv_src      <= src_d;
      mv_dst      <= dst_d;
      err_illegal <= ill_d;
      err_timeout <= to_d;
      halted      <= halt_d;
      move_count  <= cnt_d;
    end
  end

`ifdef FREECELL_AUTO_HOME_EN
  // Home-sweep bookkeeping: slot index, pass success and auto-move tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx <= '0;
      any_ok   <= 1'b0;
      auto_mv  <= 1'b0;
    end else begin
      scan_idx <= scan_idx_d;
      any_ok   <= any_ok_d;
      auto_mv  <= auto_mv_d;
    end
  end
`endif

endmodule
